vga_timing_obj_gen: RTL
=======================

Name: vga_timing_obj_gen

Overview:
- Parametrised successor to the fixed-mode VGA controller. Generates VGA timing from per-mode parameters and a pixel clock-enable derived from the system clock.
- Draws one solid rectangle object over a background colour.
- Object and background settings arrive from the LiteX CSR side and are double-buffered, so they apply only at frame boundaries and never tear.
- Sits between the LiteX SoC wrapper and the ADV7125 DAC pins.

Parameters:
- CW, 8, bits per colour channel (rgb = 3*CW).
- CLK_DIV, 4, system clocks per pixel; must be >= 2.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.
- HS_POL, 0, hsync active level.
- VS_POL, 0, vsync active level.
- XW, 11, coordinate width (holds H_TOTAL-1 and V_TOTAL-1).

Ports:
- vga_clk  in  1  system clock (clk100 at top level).
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  one-cycle strobe; captures all cfg_* inputs into pending registers.
- cfg_obj_x  in  XW  object left column.
- cfg_obj_y  in  XW  object top line.
- cfg_obj_w  in  XW  object width; 0 disables the object.
- cfg_obj_h  in  XW  object height; 0 disables the object.
- cfg_obj_color  in  3*CW  object colour {r,g,b}.
- cfg_bg_color  in  3*CW  background colour {r,g,b}.
- cfg_pending  out  1  high while a captured config has not yet been applied.
- frame_start  out  1  one-cycle pulse on the system clock when pixel (0,0) is emitted.
- vga_clk_out  out  1  pixel clock to DAC; high for the first CLK_DIV/2 system clocks of each pixel period.
- vga_hsync  out  1  horizontal sync.
- vga_vsync  out  1  vertical sync.
- vga_r  out  CW  red channel.
- vga_g  out  CW  green channel.
- vga_b  out  CW  blue channel.

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise from the V_* parameters.
- Pixel clock-enable:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_ce is high when div_cnt == CLK_DIV-1.
  - vga_clk_out is registered, high while div_cnt < CLK_DIV/2.
- Pixel counters:
  - h_cnt and v_cnt advance only on pix_ce.
  - h_cnt wraps at H_TOTAL-1 to 0; on that wrap v_cnt increments.
  - v_cnt wraps at V_TOTAL-1 to 0.
- Sync decode:
  - hsync active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
  - Output levels follow HS_POL and VS_POL.
- Visible region: active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Object hit:
  - hit = obj_x <= h_cnt < obj_x+obj_w, and obj_y <= v_cnt < obj_y+obj_h.
  - Compare in XW+1 bits so obj_x+obj_w never overflows.
  - An object extending past the visible area is clipped.
  - w=0 or h=0 gives no hit.
- Colour selection: colour = active ? (hit ? obj_color : bg_color) : 0.
- Output pipeline:
  - Sync and colour outputs are registered on pix_ce.
  - Latency is exactly one pixel period from counter state to pins.
  - hsync, vsync and rgb stay mutually aligned.
- Config double-buffering:
  - cfg_valid loads the pending registers and sets cfg_pending.
  - Apply point: pix_ce with h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1. There the shadow (active) registers take the pending values and cfg_pending clears.
  - cfg_valid on the apply cycle: the shadow takes the old pending values, the new values go to pending, and cfg_pending stays 1.
  - Repeated cfg_valid before apply: last write wins.
- frame_start: asserts for one system clock on the pix_ce that registers pixel (0,0) onto the outputs.
- Reset (synchronous, while rst=1):
  - Counters, div_cnt, pending and shadow registers are cleared to 0.
  - Outputs: rgb=0, cfg_pending=0, frame_start=0, vga_clk_out=0, syncs at inactive level (~HS_POL, ~VS_POL).
  - After release, the first pixel period starts at h=0, v=0.
  - Reset mid-frame restarts timing at (0,0) and discards any pending config.

Test Plan:
- Small mode: CLK_DIV=2, H=8/2/2/2 (H_TOTAL=14), V=4/1/1/1 (V_TOTAL=7), CW=8. Hold rst 3 cycles, then release.
  -> vga_clk_out period 2 clocks, 50% duty.
  -> hsync low for pixels 10-11 of each line.
  -> vsync low for line 5.
  -> frame_start every 196 clocks.
- Set cfg_bg_color=0x102030, obj=(2,1,3,2), color=0xFF0000, cfg_valid mid-frame.
  -> cfg_pending=1 until frame end; current frame unchanged.
  -> Next frame: pixels x2-4 on lines 1-2 = FF/00/00; other visible pixels = 10/20/30; blanking = 0.
- Object at x=6, w=5. -> Only x=6 and x=7 coloured; no wrap into the next line.
- cfg_valid pulsed exactly on the apply cycle with new colour 0x00FF00.
  -> Next frame uses the previous pending values.
  -> cfg_pending stays 1; green appears one frame later.
- w=0 with h=2. -> Whole frame is background.
- rst asserted at h=5, v=2 for 1 cycle.
  -> Outputs go to reset values next cycle; pending cleared.
  -> Timing restarts at (0,0); frame_start fires 2 clocks (one pixel period) after pixel (0,0) is counted.

Source files
------------

// File: rtl/vga_timing_obj_gen_if.sv
// vga_timing_obj_gen_if: CSR-side configuration port of the VGA object generator
interface vga_timing_obj_gen_if #(
  parameter int XW = 11,
  parameter int CW = 8
);
  logic            cfg_valid;
  logic [XW-1:0]   cfg_obj_x;
  logic [XW-1:0]   cfg_obj_y;
  logic [XW-1:0]   cfg_obj_w;
  logic [XW-1:0]   cfg_obj_h;
  logic [3*CW-1:0] cfg_obj_color;
  logic [3*CW-1:0] cfg_bg_color;
  logic            cfg_pending;
  modport master (
    output cfg_valid, cfg_obj_x, cfg_obj_y, cfg_obj_w, cfg_obj_h, cfg_obj_color, cfg_bg_color,
    input  cfg_pending
  );
  modport slave (
    input  cfg_valid, cfg_obj_x, cfg_obj_y, cfg_obj_w, cfg_obj_h, cfg_obj_color, cfg_bg_color,
    output cfg_pending
  );
endinterface

// File: rtl/vga_timing_obj_gen.sv
// vga_timing_obj_gen: parametrised VGA timing with one double-buffered solid rectangle over a background
module vga_timing_obj_gen #(
  parameter int CW       = 8,
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int XW       = 11
) (
  input  logic          vga_clk,
  input  logic          rst,
  vga_timing_obj_gen_if.slave cfg,
  output logic          frame_start,
  output logic          vga_clk_out,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic [CW-1:0] vga_r,
  output logic [CW-1:0] vga_g,
  output logic [CW-1:0] vga_b
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);
  typedef struct packed {
    logic [XW-1:0]   x;
    logic [XW-1:0]   y;
    logic [XW-1:0]   w;
    logic [XW-1:0]   h;
    logic [3*CW-1:0] oc;
    logic [3*CW-1:0] bg;
  } cfg_t;
  logic [DW-1:0]   div_q, div_d;
  logic [XW-1:0]   h_q, h_d, v_q, v_d;
  cfg_t            pend_q, pend_d, shad_q, shad_d;
  logic            pending_q, pending_d;
  logic            hs_q, hs_d, vs_q, vs_d, fs_q, fs_d, clk_q, clk_d;
  logic [3*CW-1:0] rgb_q, rgb_d;
  logic            pix_ce, h_end, v_end, apply, active, hit, hs_act, vs_act;
  always_comb begin
    pix_ce    = div_q == DW'(CLK_DIV - 1);
    h_end     = h_q == XW'(H_TOTAL - 1);
    v_end     = v_q == XW'(V_TOTAL - 1);
    apply     = pix_ce && h_end && v_end;
    div_d     = pix_ce ? '0 : div_q + 1'b1;
    h_d       = pix_ce ? (h_end ? '0 : h_q + 1'b1) : h_q;
    v_d       = (pix_ce && h_end) ? (v_end ? '0 : v_q + 1'b1) : v_q;
    // Object bounds use one extra bit so x+w cannot wrap around
    hit       = ({1'b0, h_q} >= {1'b0, shad_q.x}) && ({1'b0, h_q} < {1'b0, shad_q.x} + {1'b0, shad_q.w}) &&
                ({1'b0, v_q} >= {1'b0, shad_q.y}) && ({1'b0, v_q} < {1'b0, shad_q.y} + {1'b0, shad_q.h});
    active    = (h_q < XW'(H_ACTIVE)) && (v_q < XW'(V_ACTIVE));
    hs_act    = (h_q >= XW'(H_ACTIVE + H_FP)) && (h_q < XW'(H_ACTIVE + H_FP + H_SYNC));
    vs_act    = (v_q >= XW'(V_ACTIVE + V_FP)) && (v_q < XW'(V_ACTIVE + V_FP + V_SYNC));
    hs_d      = pix_ce ? (hs_act ? HS_POL : ~HS_POL) : hs_q;
    vs_d      = pix_ce ? (vs_act ? VS_POL : ~VS_POL) : vs_q;
    rgb_d     = pix_ce ? (active ? (hit ? shad_q.oc : shad_q.bg) : '0) : rgb_q;
    fs_d      = pix_ce && h_q == '0 && v_q == '0;
    clk_d     = div_q < DW'(CLK_DIV / 2);
    // On a simultaneous write and apply, the shadow takes the older pending set
    shad_d    = apply ? pend_q : shad_q;
    pend_d    = cfg.cfg_valid ? cfg_t'({cfg.cfg_obj_x, cfg.cfg_obj_y, cfg.cfg_obj_w, cfg.cfg_obj_h,
                                        cfg.cfg_obj_color, cfg.cfg_bg_color}) : pend_q;
    pending_d = cfg.cfg_valid || (pending_q && !apply);
  end
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      div_q     <= '0;
      h_q       <= '0;
      v_q       <= '0;
      pend_q    <= '0;
      shad_q    <= '0;
      pending_q <= 1'b0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      rgb_q     <= '0;
      fs_q      <= 1'b0;
      clk_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      pend_q    <= pend_d;
      shad_q    <= shad_d;
      pending_q <= pending_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      rgb_q     <= rgb_d;
      fs_q      <= fs_d;
      clk_q     <= clk_d;
    end
  end
  assign cfg.cfg_pending       = pending_q;
  assign frame_start           = fs_q;
  assign vga_clk_out           = clk_q;
  assign vga_hsync             = hs_q;
  assign vga_vsync             = vs_q;
  assign {vga_r, vga_g, vga_b} = rgb_q;
endmodule
